// File: rtl/s_routing_table.sv
// -----------------------------------------------------------------------------
// s_routing_table
//   Per-port next-hop decoder for the mesh router. It sits between a port's
//   input FIFO and the internal arbiter bus. It reads the destination row and
//   column and the routing mode from the packet header, then replaces the
//   packet's next-hop byte with the output port the packet must leave through.
//   The output is fully registered and has one cycle of latency.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset (0 = reset)
//   data_in    in   [pckg_sz]  packet from the port input FIFO
//   pndng_in   in   data_in holds a valid packet
//   data_out   out  [pckg_sz]  packet with the next-hop byte rewritten
//   pndng_out  out  pndng_in delayed by one cycle
//   route_err  out  the destination of the routed packet was invalid
//
// Packet layout (MSB first)
//   [pckg_sz-1 :pckg_sz-8 ]  next-hop byte (overwritten)
//   [pckg_sz-9 :pckg_sz-12]  tgt_r
//   [pckg_sz-13:pckg_sz-16]  tgt_c
//   [pckg_sz-17]             mode (1 = row first, 0 = column first)
//   [pckg_sz-18:0]           payload
// -----------------------------------------------------------------------------
module s_routing_table #(
  parameter int pckg_sz = 40,
  parameter int id_r    = 1,
  parameter int id_c    = 1,
  parameter int columns = 4,
  parameter int rows    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [pckg_sz-1:0] data_in,
  input  logic               pndng_in,
  output logic [pckg_sz-1:0] data_out,
  output logic               pndng_out,
  output logic               route_err
);

  localparam logic [7:0] ID_R  = 8'(id_r);
  localparam logic [7:0] ID_C  = 8'(id_c);
  localparam logic [7:0] MAX_R = 8'(rows + 1);
  localparam logic [7:0] MAX_C = 8'(columns + 1);

  localparam logic [7:0] PORT_N    = 8'h00;
  localparam logic [7:0] PORT_E    = 8'h01;
  localparam logic [7:0] PORT_S    = 8'h02;
  localparam logic [7:0] PORT_W    = 8'h03;
  localparam logic [7:0] HOP_BCAST = 8'hFF;

  // Dimension-ordered route choice. For an invalid destination, the caller
  // replaces the result with the broadcast code.
  function automatic logic [7:0] pick_port(input logic [7:0] tr,
                                           input logic [7:0] tc,
                                           input logic       row_first);
    logic [7:0] port;
    port = PORT_N;
    if (row_first) begin
      if      (tr < ID_R) port = PORT_N;
      else if (tr > ID_R) port = PORT_S;
      else if (tc > ID_C) port = PORT_E;
      else if (tc < ID_C) port = PORT_W;
    end else begin
      if      (tc > ID_C) port = PORT_E;
      else if (tc < ID_C) port = PORT_W;
      else if (tr < ID_R) port = PORT_N;
      else if (tr > ID_R) port = PORT_S;
    end
    return port;
  endfunction

  logic [7:0]         tgt_r;
  logic [7:0]         tgt_c;
  logic               mode;
  logic               invalid;
  logic [7:0]         next_hop;

  logic [pckg_sz-1:0] data_d,  data_q;
  logic               pndng_d, pndng_q;
  logic               err_d,   err_q;

  always_comb begin
    tgt_r   = {4'b0000, data_in[pckg_sz-9  -: 4]};
    tgt_c   = {4'b0000, data_in[pckg_sz-13 -: 4]};
    mode    = data_in[pckg_sz-17];

    // A packet addressed to this router has no exit port. Coordinates
    // beyond the terminal ring are malformed.
    invalid = ((tgt_r == ID_R) && (tgt_c == ID_C)) ||
              (tgt_r > MAX_R) || (tgt_c > MAX_C);

    next_hop = invalid ? HOP_BCAST : pick_port(tgt_r, tgt_c, mode);

    data_d  = {next_hop, data_in[pckg_sz-9:0]};
    pndng_d = pndng_in;
    err_d   = pndng_in & invalid;
  end

  // Output stage: loads every cycle, whether or not a packet is pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      pndng_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      pndng_q <= pndng_d;
      err_q   <= err_d;
    end
  end

  assign data_out  = data_q;
  assign pndng_out = pndng_q;
  assign route_err = err_q;

endmodule

// File: tb/tb_s_routing_table.sv
// -----------------------------------------------------------------------------
// tb_s_routing_table
//   Directed testbench for s_routing_table, configured with pckg_sz=40,
//   rows=4, columns=4, id_r=2 and id_c=2. Each scenario task drives its own
//   vectors and checks the results against hand-computed values.
// -----------------------------------------------------------------------------
module tb_s_routing_table;

  localparam int W = 40;

  logic         clk;
  logic         rst;
  logic [W-1:0] data_in;
  logic         pndng_in;
  logic [W-1:0] data_out;
  logic         pndng_out;
  logic         route_err;

  int n_checks;
  int n_fail;

  s_routing_table #(
    .pckg_sz (W),
    .id_r    (2),
    .id_c    (2),
    .columns (4),
    .rows    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .pndng_in  (pndng_in),
    .data_out  (data_out),
    .pndng_out (pndng_out),
    .route_err (route_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs on the falling edge, then return 1 time unit after the
  // next rising edge, when the registered result can be sampled.
  task automatic drive(input logic [W-1:0] d, input logic p);
    @(negedge clk);
    data_in  = d;
    pndng_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst      = 1'b0;
    data_in  = 40'hFF_FFFF_FFFF;
    pndng_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== 40'h0 || pndng_out !== 1'b0 || route_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got data_out=%h pndng_out=%b route_err=%b, want 0000000000 0 0",
               data_out, pndng_out, route_err);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_row_first;
    drive(40'h0003801234, 1'b1);
    n_checks++;
    if (data_out !== 40'h0003801234 || pndng_out !== 1'b1 || route_err !== 1'b0) begin
      n_fail++;
      $display("FAIL row_north: got %h %b %b, want 0003801234 1 0", data_out, pndng_out, route_err);
    end
    drive(40'hAB52801234, 1'b1);
    n_checks++;
    if (data_out !== 40'h0252801234 || pndng_out !== 1'b1 || route_err !== 1'b0) begin
      n_fail++;
      $display("FAIL row_south_stale: got %h %b %b, want 0252801234 1 0", data_out, pndng_out, route_err);
    end
    drive(40'h0024801234, 1'b1);
    n_checks++;
    if (data_out !== 40'h0124801234 || route_err !== 1'b0) begin
      n_fail++;
      $display("FAIL row_east: got %h %b, want 0124801234 0", data_out, route_err);
    end
    drive(40'h0021801234, 1'b1);
    n_checks++;
    if (data_out !== 40'h0321801234 || route_err !== 1'b0) begin
      n_fail++;
      $display("FAIL row_west: got %h %b, want 0321801234 0", data_out, route_err);
    end
  endtask

  task automatic test_col_first;
    drive(40'h0003001234, 1'b1);
    n_checks++;
    if (data_out !== 40'h0103001234 || pndng_out !== 1'b1 || route_err !== 1'b0) begin
      n_fail++;
      $display("FAIL col_east: got %h %b %b, want 0103001234 1 0", data_out, pndng_out, route_err);
    end
    drive(40'h0020001234, 1'b1);
    n_checks++;
    if (data_out !== 40'h0320001234 || route_err !== 1'b0) begin
      n_fail++;
      $display("FAIL col_west: got %h %b, want 0320001234 0", data_out, route_err);
    end
    drive(40'h0012001234, 1'b1);
    n_checks++;
    if (data_out !== 40'h0012001234 || route_err !== 1'b0) begin
      n_fail++;
      $display("FAIL col_north: got %h %b, want 0012001234 0", data_out, route_err);
    end
    drive(40'h7732001234, 1'b1);
    n_checks++;
    if (data_out !== 40'h0232001234 || route_err !== 1'b0) begin
      n_fail++;
      $display("FAIL col_south: got %h %b, want 0232001234 0", data_out, route_err);
    end
  endtask

  task automatic test_invalid;
    drive(40'h0022801234, 1'b1);
    n_checks++;
    if (data_out !== 40'hFF22801234 || pndng_out !== 1'b1 || route_err !== 1'b1) begin
      n_fail++;
      $display("FAIL inv_self: got %h %b %b, want FF22801234 1 1", data_out, pndng_out, route_err);
    end
    drive(40'h0022801234, 1'b0);
    n_checks++;
    if (data_out !== 40'hFF22801234 || pndng_out !== 1'b0 || route_err !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_self_idle: got %h %b %b, want FF22801234 0 0", data_out, pndng_out, route_err);
    end
    drive(40'h0062801234, 1'b1);
    n_checks++;
    if (data_out !== 40'hFF62801234 || route_err !== 1'b1) begin
      n_fail++;
      $display("FAIL inv_row_range: got %h %b, want FF62801234 1", data_out, route_err);
    end
    drive(40'h0026001234, 1'b1);
    n_checks++;
    if (data_out !== 40'hFF26001234 || route_err !== 1'b1) begin
      n_fail++;
      $display("FAIL inv_col_range: got %h %b, want FF26001234 1", data_out, route_err);
    end
    // Coordinate 5 is the terminal ring and therefore still valid.
    drive(40'h0025801234, 1'b1);
    n_checks++;
    if (data_out !== 40'h0125801234 || route_err !== 1'b0) begin
      n_fail++;
      $display("FAIL edge_col_terminal: got %h %b, want 0125801234 0", data_out, route_err);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] vin  [4];
    logic         pin  [4];
    logic [W-1:0] vexp [4];
    logic         eerr [4];
    vin[0] = 40'h0003801234; pin[0] = 1'b1; vexp[0] = 40'h0003801234; eerr[0] = 1'b0;
    vin[1] = 40'h0022801234; pin[1] = 1'b1; vexp[1] = 40'hFF22801234; eerr[1] = 1'b1;
    vin[2] = 40'h0020001234; pin[2] = 1'b0; vexp[2] = 40'h0320001234; eerr[2] = 1'b0;
    vin[3] = 40'h5552801234; pin[3] = 1'b1; vexp[3] = 40'h0252801234; eerr[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(vin[i], pin[i]);
      n_checks++;
      if (data_out !== vexp[i] || pndng_out !== pin[i] || route_err !== eerr[i]) begin
        n_fail++;
        $display("FAIL b2b_%0d: got %h %b %b, want %h %b %b", i,
                 data_out, pndng_out, route_err, vexp[i], pin[i], eerr[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    drive(40'h0022801234, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (data_out !== 40'h0 || pndng_out !== 1'b0 || route_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %h %b %b, want 0000000000 0 0", data_out, pndng_out, route_err);
    end
    data_in  = 40'h0024801234;
    pndng_in = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (data_out !== 40'h0124801234 || pndng_out !== 1'b1 || route_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got %h %b %b, want 0124801234 1 0", data_out, pndng_out, route_err);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_row_first();
    test_col_first();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/s_routing_table.md
Name: s_routing_table

Overview:
- Per-port next-hop decoder for the mesh router.
- One instance sits on each of the 4 router ports, between the port's input FIFO output and the internal arbiter bus.
- It reads the destination row/column and routing mode from an incoming packet and overwrites the packet's next-hop byte with the router output port the packet must leave through.
- The result is presented one clock later, together with a delayed pending flag and a routing-error flag.

Parameters:
- pckg_sz, 40, packet width in bits; must be >= 17.
- id_r, 1, row coordinate of the owning router (routers occupy rows 1..rows).
- id_c, 1, column coordinate of the owning router (routers occupy columns 1..columns).
- columns, 4, mesh column count; terminals sit at columns 0 and columns+1.
- rows, 4, mesh row count; terminals sit at rows 0 and rows+1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- data_in  input  pckg_sz  packet from the port input FIFO.
- pndng_in  input  1  data_in holds a valid packet.
- data_out  output  pckg_sz  packet with next-hop byte rewritten.
- pndng_out  output  1  pndng_in delayed one cycle.
- route_err  output  1  destination invalid for the packet just routed.

Behaviour:
- Packet fields:
  - next-hop = [pckg_sz-1:pckg_sz-8]
  - tgt_r = [pckg_sz-9:pckg_sz-12]
  - tgt_c = [pckg_sz-13:pckg_sz-16]
  - mode = [pckg_sz-17]
  - the remaining low bits are payload.
- Port encoding:
  - 0 = north (row-1)
  - 1 = east (col+1)
  - 2 = south (row+1)
  - 3 = west (col-1)
- mode=1 (row first):
  - tgt_r<id_r -> 0
  - tgt_r>id_r -> 2
  - else tgt_c>id_c -> 1
  - else tgt_c<id_c -> 3
- mode=0 (column first):
  - tgt_c>id_c -> 1
  - tgt_c<id_c -> 3
  - else tgt_r<id_r -> 0
  - else tgt_r>id_r -> 2
- Invalid destination is any of:
  - tgt_r==id_r and tgt_c==id_c
  - tgt_r>rows+1
  - tgt_c>columns+1
  - On invalid destination: next-hop = 8'hFF (broadcast code) and the packet is not otherwise altered.
- All comparisons are unsigned, zero-extended to 8 bits. The next-hop value is zero-extended to 8 bits (e.g. 2 -> 8'h02).
- Output word: data_out = {next-hop, data_in[pckg_sz-9:0]}. All bits below the next-hop byte pass through unchanged, and the incoming next-hop byte is discarded.
- Timing:
  - Fully registered; latency is exactly 1 cycle.
  - Registers load on every rising clk edge, regardless of pndng_in.
  - pndng_out <= pndng_in.
  - route_err <= pndng_in & invalid.
  - Throughput is 1 packet per cycle; there is no backpressure and no internal state beyond the output registers.
- Reset: while rst=0, data_out=0, pndng_out=0 and route_err=0, immediately (asynchronously).
- Reset mid-operation: the in-flight packet is dropped. The first edge after rst rises registers the current data_in normally.
- pndng_in=0: data_out still updates (value is don't-care downstream) and route_err=0.

Test Plan (pckg_sz=40, rows=4, columns=4, id_r=2, id_c=2):
- Row first, north: data_in=40'h0003801234, pndng_in=1 -> next cycle data_out=40'h0003801234, pndng_out=1, route_err=0.
- Column first, east: data_in=40'h0003001234 -> data_out=40'h0103001234.
- Row first, south, stale next-hop overwritten: data_in=40'hAB52801234 -> data_out=40'h0252801234.
- Column first, west: data_in=40'h0020001234 -> data_out=40'h0320001234.
- Invalid destination, equal to the router: data_in=40'h0022801234, pndng_in=1 -> data_out=40'hFF22801234, route_err=1. Repeat with pndng_in=0 -> route_err=0.
- Invalid destination, out of range: data_in=40'h0062801234 (tgt_r=6 > rows+1), pndng_in=1 -> data_out=40'hFF62801234, route_err=1.
- Reset mid-stream: pulse rst=0 between clock edges while pndng_in=1 -> data_out=0, pndng_out=0 and route_err=0 at once. After release, the next packet appears 1 cycle later.
